// File: rtl/sequenciador_pkg.sv
// Shared types and constants for the 3-bit select-code sequencer.
// Holds the code width, default dwell, FSM state type, code type and
// a helper that computes the plain modulo-8 neighbour of a code.
package sequenciador_pkg;

    localparam int unsigned CODE_W    = 3;
    localparam int unsigned DWELL_DEF = 4;

    typedef enum logic {
        OCIOSO   = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    typedef logic [CODE_W-1:0] codigo_t;

    localparam codigo_t CODE_MAX = '1;

    // Modulo-2^CODE_W neighbour: down=0 steps up, down=1 steps down.
    function automatic codigo_t step_code(input codigo_t c, input logic down);
        return down ? codigo_t'(c - codigo_t'(1)) : codigo_t'(c + codigo_t'(1));
    endfunction

endpackage

// File: rtl/sequenciador_3b_divisor_tick.sv
// divisor_tick: dwell prescaler for the sequencer.
// Counts enabled cycles 0..DWELL-1 and flags the last one.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset (prescaler <= 0)
//   en   - count enable; prescaler holds when low
//   clr  - synchronous clear of the prescaler (used on load)
//   tick - high while en=1 and prescaler == DWELL-1
module divisor_tick
    import sequenciador_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PRE_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DWELL - 1);

    logic [PRE_W-1:0] prescaler;

    // Prescaler: clear has priority over counting; wraps at DWELL-1.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prescaler <= '0;
        end else if (en) begin
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    assign tick = en && (prescaler == PRE_LAST);

endmodule

// File: rtl/sequenciador_3b.sv
// sequenciador_3b: generates the 3-bit select code b2..b0 for a 3-to-8
// decoder, advancing one code every DWELL enabled cycles.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   en       - 1 runs the dwell counter, 0 freezes everything
//   dir      - 0 counts up, 1 counts down (sampled at an advance)
//   load     - synchronous load strobe, overrides en
//   load_val - code loaded when load=1
//   b2,b1,b0 - registered select code (b2 = MSB)
//   step     - one-cycle pulse when a new code appears via an advance
//   wrap     - pulse with step on 7->0 / 0->7
// Build option: SEQUENCIADOR_PING_PONG_EN replaces modulo stepping with a
// bouncing 0..7..0 sequence driven by an internal direction flag; dir is
// then ignored and wrap marks the 7->6 and 0->1 turnarounds.
module sequenciador_3b
    import sequenciador_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [CODE_W-1:0] load_val,
    output logic              b2,
    output logic              b1,
    output logic              b0,
    output logic              step,
    output logic              wrap
);

    estado_t estado;
    codigo_t code;
    logic    tick;

`ifdef SEQUENCIADOR_PING_PONG_EN
    logic flag_down;
    logic unused_dir;
    assign unused_dir = dir;
`endif

    divisor_tick #(
        .DWELL(DWELL)
    ) u_divisor (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .tick(tick)
    );

    // FSM, code register and strobes: rst > load > advance > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
            code   <= '0;
            step   <= 1'b0;
            wrap   <= 1'b0;
`ifdef SEQUENCIADOR_PING_PONG_EN
            flag_down <= 1'b0;
`endif
        end else begin
            // en is ignored while loading, so the state holds that cycle.
            if (!load) begin
                case (estado)
                    OCIOSO:   if (en)  estado <= CONTANDO;
                    CONTANDO: if (!en) estado <= OCIOSO;
                endcase
            end

            step <= 1'b0;
            wrap <= 1'b0;

            if (load) begin
                code <= codigo_t'(load_val);
            end else if (tick) begin
                step <= 1'b1;
`ifdef SEQUENCIADOR_PING_PONG_EN
                if (!flag_down && code == CODE_MAX) begin
                    code      <= step_code(code, 1'b1);
                    flag_down <= 1'b1;
                    wrap      <= 1'b1;
                end else if (flag_down && code == '0) begin
                    code      <= step_code(code, 1'b0);
                    flag_down <= 1'b0;
                    wrap      <= 1'b1;
                end else begin
                    code <= step_code(code, flag_down);
                end
`else
                code <= step_code(code, dir);
                wrap <= dir ? (code == '0) : (code == CODE_MAX);
`endif
            end
        end
    end

    assign b2 = code[2];
    assign b1 = code[1];
    assign b0 = code[0];

endmodule
